// File: rtl/dvp_pkg.sv
// dvp_pkg: FSM states, counter widths and RGB565 colour bars shared by the DVP transmitter.
package dvp_pkg;
  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP} state_t;
  localparam int BYTE_CW = 17;
  localparam int LINE_CW = 16;
  localparam int CNT_W = BYTE_CW + 1;
  // White, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [15:0] bar_rgb(input logic [2:0] i);
    case (i)
      3'd0: return 16'hFFFF;
      3'd1: return 16'hFFE0;
      3'd2: return 16'h07FF;
      3'd3: return 16'h07E0;
      3'd4: return 16'hF81F;
      3'd5: return 16'hF800;
      3'd6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction
endpackage

// File: rtl/dvp_tx_timing_gen.sv
// dvp_tx_timing_gen: pclk phase, frame FSM and counters producing DVP sync and byte strobes.
// DVP_TX_TEST_PATTERN_EN adds the colour-bar index output.
module dvp_tx_timing_gen
  import dvp_pkg::*;
#(
  parameter int VSYNC_PCLKS  = 16,
  parameter int VBP_LINES    = 2,
  parameter int VFP_LINES    = 2,
  parameter int HBLANK_PCLKS = 32
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        enable_i,
  input  logic [15:0] resolution_width_i,
  input  logic [15:0] resolution_depth_i,
  output logic        tick_o,
  output logic        href_o,
  output logic        vsync_o,
  output logic        frame_done_o,
  output logic        frame_start_o,
  output logic        load_o,
  output logic        low_o
`ifdef DVP_TX_TEST_PATTERN_EN
  ,
  output logic [2:0]  bar_o
`endif
);
  localparam logic [CNT_W-1:0] VS_LAST = CNT_W'(VSYNC_PCLKS - 1);
  localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(HBLANK_PCLKS - 1);
  localparam logic [LINE_CW-1:0] VBP_LAST = LINE_CW'(VBP_LINES - 1);
  localparam logic [LINE_CW-1:0] VFP_LAST = LINE_CW'(VFP_LINES - 1);
  state_t state;
  logic ph;
  logic [CNT_W-1:0] cnt, lim;
  logic [LINE_CW-1:0] line;
  logic [15:0] width, depth;
  logic [BYTE_CW-1:0] bytes;
  logic go, last, line_done, frame_end, start_line;
  assign bytes = {width, 1'b0};
  // lim is the index of the final tick of the current state (blank lines: 2*width+HBLANK).
  assign lim = state == VSYNC ? VS_LAST : state == HBLANK ? HB_LAST :
               state == ACTIVE ? CNT_W'(bytes) - 1'b1 : CNT_W'(bytes) + HB_LAST;
  assign last = cnt == lim;
  assign go = enable_i && |resolution_width_i && |resolution_depth_i;
  assign line_done = line == depth - 1'b1;
  assign start_line = ph && last && ((state == VSYNC && VBP_LINES == 0) ||
                      (state == VBP && line == VBP_LAST) || (state == HBLANK && !line_done));
  assign frame_end = ph && last && ((state == VFP && line == VFP_LAST) ||
                     (state == HBLANK && line_done && VFP_LINES == 0));
  assign tick_o = ph;
  // load_o/low_o flag the tick whose edge starts an even/odd byte.
  assign load_o = start_line || (ph && state == ACTIVE && cnt[0] && !last);
  assign low_o = ph && state == ACTIVE && !cnt[0];
  assign frame_start_o = (ph && state == IDLE && go) || (frame_end && enable_i);
`ifdef DVP_TX_TEST_PATTERN_EN
  logic [BYTE_CW+1:0] nxt_byte;
  assign nxt_byte = start_line ? '0 : {cnt[BYTE_CW-1:0] + 1'b1, 2'b00};
  assign bar_o = 3'(nxt_byte / (BYTE_CW + 2)'(width));
`endif
  always_ff @(posedge clk_i or negedge resetn_i)
    if (!resetn_i) begin
      ph <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      line <= '0;
      width <= '0;
      depth <= '0;
      href_o <= 1'b0;
      vsync_o <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      ph <= ~ph;
      frame_done_o <= frame_end;
      if (ph) begin
        cnt <= (last || state == IDLE) ? '0 : cnt + 1'b1;
        case (state)
          IDLE: if (go) begin
            state <= VSYNC;
            vsync_o <= 1'b1;
            width <= resolution_width_i;
            depth <= resolution_depth_i;
          end
          VSYNC: if (last) begin
            vsync_o <= 1'b0;
            line <= '0;
            state <= VBP_LINES == 0 ? ACTIVE : VBP;
            href_o <= VBP_LINES == 0;
          end
          VBP: if (last) begin
            line <= line == VBP_LAST ? '0 : line + 1'b1;
            if (line == VBP_LAST) begin
              state <= ACTIVE;
              href_o <= 1'b1;
            end
          end
          ACTIVE: if (last) begin
            state <= HBLANK;
            href_o <= 1'b0;
          end
          HBLANK: if (last) begin
            line <= line_done ? '0 : line + 1'b1;
            state <= !line_done ? ACTIVE : VFP_LINES != 0 ? VFP : enable_i ? VSYNC : IDLE;
            href_o <= !line_done;
            vsync_o <= line_done && VFP_LINES == 0 && enable_i;
          end
          VFP: if (last) begin
            line <= line + 1'b1;
            if (line == VFP_LAST) begin
              state <= enable_i ? VSYNC : IDLE;
              vsync_o <= enable_i;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: rtl/dvp_pixel_transmitter.sv
// dvp_pixel_transmitter: regenerates a DVP camera stream from RGB565 FIFO words, high byte first.
// DVP_TX_TEST_PATTERN_EN replaces the FIFO source with an internal 8-bar colour pattern.
module dvp_pixel_transmitter
  import dvp_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int VSYNC_PCLKS  = 16,
  parameter int VBP_LINES    = 2,
  parameter int VFP_LINES    = 2,
  parameter int HBLANK_PCLKS = 32
) (
  input  logic                    clk_i,
  input  logic                    resetn_i,
  input  logic                    enable_i,
  input  logic [15:0]             resolution_width_i,
  input  logic [15:0]             resolution_depth_i,
  input  logic [2*DATA_WIDTH-1:0] pixel_data_i,
  input  logic                    empty_i,
  output logic                    rd_o,
  output logic                    dvp_pclk_o,
  output logic [DATA_WIDTH-1:0]   dvp_data_o,
  output logic                    dvp_href_o,
  output logic                    dvp_vsync_o,
  output logic                    frame_done_o,
  output logic                    underflow_o
);
  logic tick, load, low, frame_start;
  logic [2*DATA_WIDTH-1:0] word, nxt_word;
`ifdef DVP_TX_TEST_PATTERN_EN
  logic [2:0] bar;
  logic unused;
  assign unused = ^{pixel_data_i, empty_i};
  assign nxt_word = (2 * DATA_WIDTH)'(bar_rgb(bar));
  assign rd_o = 1'b0;
`else
  assign nxt_word = empty_i ? '0 : pixel_data_i;
  assign rd_o = load && !empty_i;
`endif
  dvp_tx_timing_gen #(
    .VSYNC_PCLKS (VSYNC_PCLKS),
    .VBP_LINES   (VBP_LINES),
    .VFP_LINES   (VFP_LINES),
    .HBLANK_PCLKS(HBLANK_PCLKS)
  ) u_timing (
    .clk_i             (clk_i),
    .resetn_i          (resetn_i),
    .enable_i          (enable_i),
    .resolution_width_i(resolution_width_i),
    .resolution_depth_i(resolution_depth_i),
    .tick_o            (tick),
    .href_o            (dvp_href_o),
    .vsync_o           (dvp_vsync_o),
    .frame_done_o      (frame_done_o),
    .frame_start_o     (frame_start),
    .load_o            (load),
    .low_o             (low)
`ifdef DVP_TX_TEST_PATTERN_EN
    ,
    .bar_o             (bar)
`endif
  );
  assign dvp_pclk_o = tick;
  always_ff @(posedge clk_i or negedge resetn_i)
    if (!resetn_i) begin
      word <= '0;
      dvp_data_o <= '0;
      underflow_o <= 1'b0;
    end else if (tick) begin
      if (load) word <= nxt_word;
      dvp_data_o <= load ? nxt_word[2*DATA_WIDTH-1:DATA_WIDTH] : low ? word[DATA_WIDTH-1:0] : '0;
`ifndef DVP_TX_TEST_PATTERN_EN
      underflow_o <= !frame_start && (underflow_o || (load && empty_i));
`endif
    end
endmodule
